// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared types and constants for the ghost mode scheduler: mode encoding,
// FSM state encoding, counter width and the default SCATTER/CHASE schedule.
package ghost_mode_scheduler_pkg;

    localparam int NUM_PHASES = 8;
    localparam int COUNT_W    = 11;
    localparam int COUNT_MAX  = (1 << COUNT_W) - 1;

    // Encoding seen by every ghost mover.
    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_SCATTER = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_FRIGHT  = 2'd3
    } ghost_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SCATTER,
        S_CHASE,
        S_FRIGHT
    } sched_state_t;

    typedef logic [COUNT_W-1:0] count_t;
    typedef int phase_frames_t [NUM_PHASES];

    // Phase durations in frames; even index = SCATTER, odd = CHASE, 0 = forever.
    localparam phase_frames_t PHASE_FRAMES = '{420, 1200, 420, 1200, 300, 1200, 300, 0};

    // Saturate a frame count into the counter width.
    function automatic count_t clamp_count(input int frames);
        if (frames < 0) begin
            return '0;
        end
        if (frames > COUNT_MAX) begin
            return count_t'(COUNT_MAX);
        end
        return count_t'(frames);
    endfunction

    // Mode presented to the ghosts for a given scheduler state.
    function automatic ghost_mode_t mode_of(input sched_state_t s);
        case (s)
            S_SCATTER: return MODE_SCATTER;
            S_CHASE:   return MODE_CHASE;
            S_FRIGHT:  return MODE_FRIGHT;
            default:   return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_frame_down_counter.sv
// Loadable down-counter that steps once per frame strobe and holds at zero.
module frame_down_counter
    import ghost_mode_scheduler_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  count_t load_val_i,
    input  logic   tick_i,
    output count_t count_o,
    output logic   zero_o
);

    count_t count_q;

    // Load wins over the frame tick; a counter already at zero holds.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - count_t'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode scheduler: frame-timed SCATTER/CHASE schedule, FRIGHTENED on a
// power pellet with the interrupted phase held, and a start/respawn freeze.
module ghost_mode_scheduler
    import ghost_mode_scheduler_pkg::*;
#(
    parameter int            FRIGHT_FRAMES      = 360,
    parameter int            BLINK_FRAMES       = 120,
    parameter int            START_DELAY_FRAMES = 240,
    parameter phase_frames_t PHASE_TABLE        = PHASE_FRAMES
) (
    input  logic       vga_pix_clk,
    input  logic       rst,
    input  logic       frame_stb,
    input  logic       game_start,
    input  logic       power_pellet,
    input  logic       pac_dead,
    output logic [1:0] mode,
    output logic       enable_move,
    output logic       reverse_pulse,
    output logic       blink,
    output logic [2:0] phase_idx
);

    localparam count_t FRIGHT_LOAD = clamp_count(FRIGHT_FRAMES);
    localparam count_t START_LOAD  = clamp_count(START_DELAY_FRAMES);
    localparam count_t BLINK_LIM   = clamp_count(BLINK_FRAMES);
    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

    // Clamped schedule as constant nets, indexed by the next phase number.
    count_t phase_load [NUM_PHASES];
    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase_load
        localparam count_t LOAD = clamp_count(PHASE_TABLE[g]);
        assign phase_load[g] = LOAD;
    end

    sched_state_t state_q, state_d;
    ghost_mode_t  mode_q;
    logic         enable_move_q;
    logic         reverse_q, reverse_d;
    logic         blink_q, blink_d;
    logic [2:0]   phase_idx_q, phase_idx_d, phase_idx_inc;

    // The phase timer only runs in SCATTER/CHASE, so while frightened it
    // simply holds the interrupted phase's remaining frames.
    logic   ph_tick, ph_load, ph_zero, ph_expire;
    count_t ph_val, ph_count;
    // The auxiliary timer is shared by the start freeze and the fright window;
    // the two never overlap.
    logic   aux_load, aux_zero, aux_done;
    count_t aux_val, aux_count, aux_next;
    logic   in_sched;

    frame_down_counter u_phase_timer (
        .clk_i      (vga_pix_clk),
        .rst_i      (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .tick_i     (ph_tick),
        .count_o    (ph_count),
        .zero_o     (ph_zero)
    );

    frame_down_counter u_aux_timer (
        .clk_i      (vga_pix_clk),
        .rst_i      (rst),
        .load_i     (aux_load),
        .load_val_i (aux_val),
        .tick_i     (frame_stb),
        .count_o    (aux_count),
        .zero_o     (aux_zero)
    );

    assign in_sched      = (state_q == S_SCATTER) || (state_q == S_CHASE);
    assign ph_tick       = frame_stb && in_sched;
    // A phase ends on the strobe that takes it from 1 to 0; a 0 duration never ends.
    assign ph_expire     = ph_tick && !ph_zero && (ph_count[COUNT_W-1:1] == '0);
    // The freeze/fright window ends on the strobe that leaves it at 0.
    assign aux_done      = frame_stb && (aux_zero || (aux_count == count_t'(1)));
    assign phase_idx_inc = (phase_idx_q == LAST_PHASE) ? phase_idx_q : phase_idx_q + 3'd1;

    // Next-state and timer-control decode; priority pac_dead > pellet > expiry.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        reverse_d   = 1'b0;
        aux_load    = 1'b0;
        aux_val     = START_LOAD;
        ph_load     = 1'b0;
        ph_val      = phase_load[0];

        if (state_q == S_IDLE) begin
            if (game_start) begin
                state_d     = S_START;
                phase_idx_d = '0;
                aux_load    = 1'b1;
                aux_val     = START_LOAD;
            end
        end else if (pac_dead) begin
            state_d     = S_START;
            phase_idx_d = '0;
            aux_load    = 1'b1;
            aux_val     = START_LOAD;
        end else begin
            case (state_q)
                S_START: begin
                    if (aux_done) begin
                        state_d     = S_SCATTER;
                        phase_idx_d = '0;
                        ph_load     = 1'b1;
                        ph_val      = phase_load[0];
                    end
                end
                S_SCATTER, S_CHASE: begin
                    if (ph_expire) begin
                        phase_idx_d = phase_idx_inc;
                        ph_load     = 1'b1;
                        ph_val      = phase_load[phase_idx_inc];
                        state_d     = phase_idx_inc[0] ? S_CHASE : S_SCATTER;
                        reverse_d   = 1'b1;
                    end
                    // The post-expiry phase (if any) is what gets held.
                    if (power_pellet) begin
                        state_d   = S_FRIGHT;
                        aux_load  = 1'b1;
                        aux_val   = FRIGHT_LOAD;
                        reverse_d = 1'b1;
                    end
                end
                S_FRIGHT: begin
                    if (power_pellet) begin
                        aux_load  = 1'b1;
                        aux_val   = FRIGHT_LOAD;
                        reverse_d = 1'b1;
                    end else if (aux_done) begin
                        // Odd phases are CHASE, so the index alone restores the mode.
                        state_d = phase_idx_q[0] ? S_CHASE : S_SCATTER;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Blink follows the fright counter's next value so it lands on the same edge.
    always_comb begin
        aux_next = aux_count;
        if (aux_load) begin
            aux_next = aux_val;
        end else if (frame_stb && !aux_zero) begin
            aux_next = aux_count - count_t'(1);
        end
        blink_d = (state_d == S_FRIGHT) && (aux_next <= BLINK_LIM);
    end

    // State register and registered outputs.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_IDLE;
            enable_move_q <= 1'b0;
            reverse_q     <= 1'b0;
            blink_q       <= 1'b0;
            phase_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_of(state_d);
            enable_move_q <= (state_d == S_SCATTER) || (state_d == S_CHASE) ||
                             (state_d == S_FRIGHT);
            reverse_q     <= reverse_d;
            blink_q       <= blink_d;
            phase_idx_q   <= phase_idx_d;
        end
    end

    assign mode          = mode_q;
    assign enable_move   = enable_move_q;
    assign reverse_pulse = reverse_q;
    assign blink         = blink_q;
    assign phase_idx     = phase_idx_q;

endmodule
